// File: rtl/z_core_pkg.sv
// Shared Z-Core defaults and constants used by the register file and the decoder.
package z_core_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

endpackage

// File: rtl/z_core_scoreboard.sv
// Per-register busy bits: set when a load issues, cleared on load writeback.
module z_core_scoreboard
  import z_core_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rd0_addr,
  output logic          rd0_busy,
  input  logic [AW-1:0] rd1_addr,
  output logic          rd1_busy
);

  logic [NREGS-1:0] busy;
  logic             set_ok;

  assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == AW'(REG_ZERO)));

  // Set is applied after clear so a new load issued over a completing one wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_ok) busy[set_addr] <= 1'b1;
    end
  end

  assign rd0_busy = busy[rd0_addr];
  assign rd1_busy = busy[rd1_addr];

endmodule

// File: rtl/z_core_reg_file_sb.sv
// Z-Core integer register file: 2 async reads, 2 prioritised writes, optional bypass, load scoreboard.
module z_core_reg_file_sb
  import z_core_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  input  logic [XLEN-1:0] wa_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out,
  output logic            rs1_busy,
  output logic            rs2_busy
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wa_ok;
  logic            wb_ok;
  logic            sb_busy1;
  logic            sb_busy2;

  // Enables qualified by reset and the hardwired-zero rule; reused by the bypass path.
  assign wa_ok = reset && wa_en && !((ZERO_REG != 0) && (wa_addr == AW'(REG_ZERO)));
  assign wb_ok = reset && wb_en && !((ZERO_REG != 0) && (wb_addr == AW'(REG_ZERO)));

  // Port A is written last so it overrides port B on an address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wb_ok) regs[wb_addr] <= wb_data;
      if (wa_ok) regs[wa_addr] <= wa_data;
    end
  end

  always_comb begin
    rs1_out = regs[rs1];
    if ((BYPASS != 0) && wb_ok && (wb_addr == rs1)) rs1_out = wb_data;
    if ((BYPASS != 0) && wa_ok && (wa_addr == rs1)) rs1_out = wa_data;
    if (!reset || ((ZERO_REG != 0) && (rs1 == AW'(REG_ZERO)))) rs1_out = '0;
  end

  always_comb begin
    rs2_out = regs[rs2];
    if ((BYPASS != 0) && wb_ok && (wb_addr == rs2)) rs2_out = wb_data;
    if ((BYPASS != 0) && wa_ok && (wa_addr == rs2)) rs2_out = wa_data;
    if (!reset || ((ZERO_REG != 0) && (rs2 == AW'(REG_ZERO)))) rs2_out = '0;
  end

  z_core_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (sb_set),
    .set_addr (sb_addr),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .rd0_addr (rs1),
    .rd0_busy (sb_busy1),
    .rd1_addr (rs2),
    .rd1_busy (sb_busy2)
  );

  // A completing load hides its busy bit in the same cycle, matching the bypassed data.
  assign rs1_busy = reset && sb_busy1 && !((BYPASS != 0) && wb_en && (wb_addr == rs1));
  assign rs2_busy = reset && sb_busy2 && !((BYPASS != 0) && wb_en && (wb_addr == rs2));

endmodule

// File: tb/tb_z_core_reg_file_sb.sv
// Directed bench for z_core_reg_file_sb across bypass, zero-register and width configurations.
module tb_z_core_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wa_en, wb_en, sb_set;
  logic [4:0]  wa_addr, wb_addr, sb_addr, rs1, rs2;
  logic [31:0] wa_data, wb_data;

  logic [31:0] d_rs1, d_rs2, z_rs1, z_rs2, n_rs1, n_rs2;
  logic        d_b1, d_b2, z_b1, z_b2, n_b1, n_b2;

  logic        w_wa_en, w_wb_en, w_sb_set;
  logic [3:0]  w_wa_addr, w_wb_addr, w_sb_addr, w_rs1, w_rs2;
  logic [63:0] w_wa_data, w_wb_data, w_rs1_out, w_rs2_out;
  logic        w_b1, w_b2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Default configuration: bypass on, x0 hardwired.
  z_core_reg_file_sb u_def (
    .clk(clk), .reset(reset),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .rs1(rs1), .rs2(rs2),
    .rs1_out(d_rs1), .rs2_out(d_rs2), .rs1_busy(d_b1), .rs2_busy(d_b2)
  );

  z_core_reg_file_sb #(.ZERO_REG(0)) u_nz (
    .clk(clk), .reset(reset),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .rs1(rs1), .rs2(rs2),
    .rs1_out(z_rs1), .rs2_out(z_rs2), .rs1_busy(z_b1), .rs2_busy(z_b2)
  );

  z_core_reg_file_sb #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .rs1(rs1), .rs2(rs2),
    .rs1_out(n_rs1), .rs2_out(n_rs2), .rs1_busy(n_b1), .rs2_busy(n_b2)
  );

  z_core_reg_file_sb #(.XLEN(64), .NREGS(16)) u_wide (
    .clk(clk), .reset(reset),
    .wa_en(w_wa_en), .wa_addr(w_wa_addr), .wa_data(w_wa_data),
    .wb_en(w_wb_en), .wb_addr(w_wb_addr), .wb_data(w_wb_data),
    .sb_set(w_sb_set), .sb_addr(w_sb_addr), .rs1(w_rs1), .rs2(w_rs2),
    .rs1_out(w_rs1_out), .rs2_out(w_rs2_out), .rs1_busy(w_b1), .rs2_busy(w_b2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; sb_set = 1'b0;
    w_wa_en = 1'b0; w_wb_en = 1'b0; w_sb_set = 1'b0;
  endtask

  // Advance one edge; inputs change on the falling edge, samples follow 1 time unit later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    wa_addr = '0; wb_addr = '0; sb_addr = '0; rs1 = '0; rs2 = '0;
    wa_data = '0; wb_data = '0;
    w_wa_addr = '0; w_wb_addr = '0; w_sb_addr = '0; w_rs1 = '0; w_rs2 = '0;
    w_wa_data = '0; w_wb_data = '0;
    #2 reset = 1'b0;

    // Writes and bypass are ignored while reset is held.
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'd77; rs1 = 5'd5;
    sb_set = 1'b1; sb_addr = 5'd5;
    #1;
    check("rst_rs1_out", d_rs1, 0);
    check("rst_rs1_busy", d_b1, 0);
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    check("rst_write_ignored", n_rs1, 0);
    check("rst_sb_ignored", d_b1, 0);

    // A writes x5, then B writes x8.
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'd15; rs1 = 5'd5; rs2 = 5'd8;
    #1;
    check("byp_a_x5", d_rs1, 15);
    check("nobyp_a_x5", n_rs1, 0);
    step();
    idle();
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'd25;
    #1;
    check("stored_x5", n_rs1, 15);
    check("byp_b_x8", d_rs2, 25);
    check("nobyp_b_x8", n_rs2, 0);
    step();
    idle();
    #1;
    check("read_x5", d_rs1, 15);
    check("read_x8", d_rs2, 25);

    // Mid-cycle reset clears immediately and drops the in-flight write.
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'd99;
    #1 reset = 1'b0;
    #1;
    check("midrst_rs1", d_rs1, 0);
    check("midrst_rs2", d_rs2, 0);
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    check("midrst_x5_lost", n_rs1, 0);
    check("midrst_x8_clr", n_rs2, 0);

    // Same-address collision: A wins.
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'hAAAA_AAAA;
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hBBBB_BBBB;
    rs1 = 5'd10;
    #1;
    check("coll_bypass", d_rs1, 32'hAAAA_AAAA);
    step();
    idle();
    #1;
    check("coll_stored", n_rs1, 32'hAAAA_AAAA);

    // Different addresses both commit.
    wa_en = 1'b1; wa_addr = 5'd11; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h22;
    rs1 = 5'd11; rs2 = 5'd12;
    step();
    idle();
    #1;
    check("dual_x11", n_rs1, 32'h11);
    check("dual_x12", n_rs2, 32'h22);

    // Register 0 with and without the hardwired-zero rule.
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'd40;
    sb_set = 1'b1; sb_addr = 5'd0; rs1 = 5'd0;
    #1;
    check("x0_zero_byp", d_rs1, 0);
    check("x0_nz_byp", z_rs1, 40);
    step();
    idle();
    #1;
    check("x0_zero_data", d_rs1, 0);
    check("x0_zero_busy", d_b1, 0);
    check("x0_nz_data", z_rs1, 40);
    check("x0_nz_busy", z_b1, 1);

    // Load pending on x7, then completion.
    sb_set = 1'b1; sb_addr = 5'd7; rs2 = 5'd7;
    #1;
    check("sb_not_yet", d_b2, 0);
    step();
    idle();
    step(); step(); step();
    #1;
    check("sb_busy_byp", d_b2, 1);
    check("sb_busy_nobyp", n_b2, 1);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
    #1;
    check("wb_byp_busy", d_b2, 0);
    check("wb_byp_data", d_rs2, 32'h1234);
    check("wb_nobyp_busy", n_b2, 1);
    check("wb_nobyp_data", n_rs2, 0);
    step();
    idle();
    #1;
    check("wb_after_busy", n_b2, 0);
    check("wb_after_data", n_rs2, 32'h1234);

    // Set and clear on the same register: set wins, data commits.
    sb_set = 1'b1; sb_addr = 5'd7;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h5678;
    #1;
    check("setclr_cycle_busy", d_b2, 0);
    step();
    idle();
    #1;
    check("setclr_busy", d_b2, 1);
    check("setclr_busy_nb", n_b2, 1);
    check("setclr_data", n_rs2, 32'h5678);

    // Port A write leaves busy untouched.
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h9;
    #1;
    check("a_keep_busy_cyc", d_b2, 1);
    step();
    idle();
    #1;
    check("a_keep_busy", d_b2, 1);
    check("a_data_x7", d_rs2, 32'h9);

    // Wide configuration: 64-bit data, 16 registers.
    w_wa_en = 1'b1; w_wa_addr = 4'd15; w_wa_data = 64'hFFFF_FFFF_0000_0001;
    w_rs1 = 4'd15; w_rs2 = 4'd0;
    step();
    idle();
    w_wb_en = 1'b1; w_wb_addr = 4'd0; w_wb_data = 64'h5;
    w_sb_set = 1'b1; w_sb_addr = 4'd0;
    #1;
    check("wide_x15", w_rs1_out, 64'hFFFF_FFFF_0000_0001);
    check("wide_x0_byp", w_rs2_out, 0);
    step();
    idle();
    #1;
    check("wide_x15_hold", w_rs1_out, 64'hFFFF_FFFF_0000_0001);
    check("wide_x0_data", w_rs2_out, 0);
    check("wide_x0_busy", w_b2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
